xfer_ctrl: RTL and testbench

XFER_CTRL -- requirements
Module: xfer_ctrl

---
 rtl/packet_pkg.sv | 13 +
 rtl/xfer_port_fsm.sv | 94 +++++++++
 rtl/xfer_ctrl.sv | 142 ++++++++++++++
 tb/tb_xfer_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_pkg.sv
// Shared types and constants for the crossbar transfer controller.
package packet_pkg;

    localparam int ADDR_WIDTH        = 4;
    localparam int NUM_PORTS         = 4;
    localparam int LEN_WIDTH_DEFAULT = 6;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } port_state_t;

endpackage

// File: rtl/xfer_port_fsm.sv
// Per-input-port packet FSM: arbiter request, flit countdown and stall watchdog.
//
// state | meaning
// IDLE  | waiting for a head flit whose destinations are all free, requesting
// XFER  | owns its latched destinations, moving one flit per all-ready cycle
module xfer_port_fsm
    import packet_pkg::*;
#(
    parameter int LEN_WIDTH = LEN_WIDTH_DEFAULT,
    parameter int STALL_MAX = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_dst,
    input  logic [LEN_WIDTH-1:0]  in_len,
    input  logic [ADDR_WIDTH-1:0] out_busy,
    input  logic [ADDR_WIDTH-1:0] out_ready,
    input  logic                  grant_ok,
    output logic                  req,
    output logic                  pop,
    output logic                  last,
    output logic                  len_zero,
    output logic                  stall_hit
);

    localparam int STALL_W = $clog2(STALL_MAX + 1);

    port_state_t           state_q, state_nxt;
    logic [LEN_WIDTH-1:0]  rem_q, rem_nxt;
    logic [ADDR_WIDTH-1:0] dst_q, dst_nxt;
    logic [STALL_W-1:0]    stall_q, stall_nxt;
    logic                  all_ready;

    assign len_zero  = (in_len == '0);
    assign stall_hit = (stall_q == STALL_W'(STALL_MAX));
    // Multicast moves only when every latched destination accepts this cycle.
    assign all_ready = ((out_ready & dst_q) == dst_q);

    // State, countdown and stall registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dst_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_nxt;
            rem_q   <= rem_nxt;
            dst_q   <= dst_nxt;
            stall_q <= stall_nxt;
        end
    end

    // Next-state, request and pop decode.
    always_comb begin
        state_nxt = state_q;
        rem_nxt   = rem_q;
        dst_nxt   = dst_q;
        stall_nxt = stall_q;
        req       = 1'b0;
        pop       = 1'b0;
        last      = 1'b0;
        case (state_q)
            IDLE: begin
                stall_nxt = '0;
                req = !rst && in_valid && (in_dst != '0) && ((in_dst & out_busy) == '0);
                if (grant_ok) begin
                    state_nxt = XFER;
                    rem_nxt   = len_zero ? LEN_WIDTH'(1) : in_len;
                    dst_nxt   = in_dst;
                end
            end
            XFER: begin
                if (!rst && all_ready) begin
                    pop       = 1'b1;
                    stall_nxt = '0;
                    if (rem_q == LEN_WIDTH'(1)) begin
                        last      = 1'b1;
                        state_nxt = IDLE;
                        rem_nxt   = '0;
                        dst_nxt   = '0;
                    end else begin
                        rem_nxt = rem_q - LEN_WIDTH'(1);
                    end
                end else if (!stall_hit) begin
                    stall_nxt = stall_q + STALL_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/xfer_ctrl.sv
// Crossbar transfer controller: four input FSMs, output locks/owners, grant
// checking and sticky error flags.
module xfer_ctrl
    import packet_pkg::*;
#(
    parameter int LEN_WIDTH = LEN_WIDTH_DEFAULT,
    parameter int STALL_MAX = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            in_valid,
    input  logic [ADDR_WIDTH-1:0] in_dst0,
    input  logic [ADDR_WIDTH-1:0] in_dst1,
    input  logic [ADDR_WIDTH-1:0] in_dst2,
    input  logic [ADDR_WIDTH-1:0] in_dst3,
    input  logic [LEN_WIDTH-1:0]  in_len0,
    input  logic [LEN_WIDTH-1:0]  in_len1,
    input  logic [LEN_WIDTH-1:0]  in_len2,
    input  logic [LEN_WIDTH-1:0]  in_len3,
    output logic [3:0]            in_pop,
    output logic [3:0]            arb_req,
    output logic [ADDR_WIDTH-1:0] arb_dst0,
    output logic [ADDR_WIDTH-1:0] arb_dst1,
    output logic [ADDR_WIDTH-1:0] arb_dst2,
    output logic [ADDR_WIDTH-1:0] arb_dst3,
    input  logic [3:0]            arb_grant,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [1:0]            out_sel0,
    output logic [1:0]            out_sel1,
    output logic [1:0]            out_sel2,
    output logic [1:0]            out_sel3,
    output logic [3:0]            out_busy,
    output logic                  err_len,
    output logic                  err_grant,
    output logic                  err_stall
);

    logic [ADDR_WIDTH-1:0] dst_arr [NUM_PORTS];
    logic [LEN_WIDTH-1:0]  len_arr [NUM_PORTS];
    logic [1:0]            owner_q [ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] busy_q;
    logic [ADDR_WIDTH-1:0] claimed;
    logic [3:0]            req, pop, last, len_zero, stall_hit, grant_ok;
    logic                  grant_bad;

    assign dst_arr[0] = in_dst0;
    assign dst_arr[1] = in_dst1;
    assign dst_arr[2] = in_dst2;
    assign dst_arr[3] = in_dst3;
    assign len_arr[0] = in_len0;
    assign len_arr[1] = in_len1;
    assign len_arr[2] = in_len2;
    assign len_arr[3] = in_len3;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        xfer_port_fsm #(
            .LEN_WIDTH (LEN_WIDTH),
            .STALL_MAX (STALL_MAX)
        ) u_port (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_dst    (dst_arr[g]),
            .in_len    (len_arr[g]),
            .out_busy  (busy_q),
            .out_ready (out_ready),
            .grant_ok  (grant_ok[g]),
            .req       (req[g]),
            .pop       (pop[g]),
            .last      (last[g]),
            .len_zero  (len_zero[g]),
            .stall_hit (stall_hit[g])
        );
    end

    // Accept grants in port order; a grant to a non-requester or onto an
    // output already claimed by a lower port this cycle is dropped and flagged.
    always_comb begin
        claimed   = '0;
        grant_ok  = '0;
        grant_bad = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (arb_grant[i]) begin
                if (!req[i] || ((dst_arr[i] & claimed) != '0)) begin
                    grant_bad = 1'b1;
                end else begin
                    grant_ok[i] = 1'b1;
                    claimed     = claimed | dst_arr[i];
                end
            end
        end
    end

    // Output locks: release on the owner's last flit, then apply new grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int o = 0; o < ADDR_WIDTH; o++) owner_q[o] <= '0;
        end else begin
            for (int o = 0; o < ADDR_WIDTH; o++) begin
                if (busy_q[o] && last[owner_q[o]]) begin
                    busy_q[o]  <= 1'b0;
                    owner_q[o] <= '0;
                end
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (grant_ok[i] && dst_arr[i][o]) begin
                        busy_q[o]  <= 1'b1;
                        owner_q[o] <= 2'(i);
                    end
                end
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_len   <= 1'b0;
            err_grant <= 1'b0;
            err_stall <= 1'b0;
        end else begin
            err_len   <= err_len   | (|(grant_ok & len_zero));
            err_grant <= err_grant | grant_bad;
            err_stall <= err_stall | (|stall_hit);
        end
    end

    assign in_pop    = pop;
    assign arb_req   = req;
    assign arb_dst0  = req[0] ? in_dst0 : '0;
    assign arb_dst1  = req[1] ? in_dst1 : '0;
    assign arb_dst2  = req[2] ? in_dst2 : '0;
    assign arb_dst3  = req[3] ? in_dst3 : '0;
    assign out_valid = busy_q;
    assign out_busy  = busy_q;
    assign out_sel0  = owner_q[0];
    assign out_sel1  = owner_q[1];
    assign out_sel2  = owner_q[2];
    assign out_sel3  = owner_q[3];

endmodule

// File: tb/tb_xfer_ctrl.sv
// Testbench for xfer_ctrl: directed scenarios plus randomized traffic, all
// compared each cycle against a packet-level reference model.
module tb_xfer_ctrl;

    localparam int SMAX = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_valid;
    logic [3:0] dst_b [4];
    logic [5:0] len_b [4];
    logic [3:0] in_pop, arb_req, arb_grant, out_valid, out_ready, out_busy;
    logic [3:0] arb_dst0, arb_dst1, arb_dst2, arb_dst3;
    logic [1:0] out_sel0, out_sel1, out_sel2, out_sel3;
    logic       err_len, err_grant, err_stall;

    int n_assert = 0;
    int n_fail   = 0;

    // packet-level model: remaining flits (0 = idle), destination mask, stall count
    int         m_rem   [4];
    logic [3:0] m_mask  [4];
    int         m_stall [4];
    logic       m_elen, m_egrant, m_estall;
    int         pop_cnt [4];

    always #5 clk = ~clk;

    xfer_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_dst0   (dst_b[0]),
        .in_dst1   (dst_b[1]),
        .in_dst2   (dst_b[2]),
        .in_dst3   (dst_b[3]),
        .in_len0   (len_b[0]),
        .in_len1   (len_b[1]),
        .in_len2   (len_b[2]),
        .in_len3   (len_b[3]),
        .in_pop    (in_pop),
        .arb_req   (arb_req),
        .arb_dst0  (arb_dst0),
        .arb_dst1  (arb_dst1),
        .arb_dst2  (arb_dst2),
        .arb_dst3  (arb_dst3),
        .arb_grant (arb_grant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel0  (out_sel0),
        .out_sel1  (out_sel1),
        .out_sel2  (out_sel2),
        .out_sel3  (out_sel3),
        .out_busy  (out_busy),
        .err_len   (err_len),
        .err_grant (err_grant),
        .err_stall (err_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_busy();
        logic [3:0] b = '0;
        for (int i = 0; i < 4; i++) if (m_rem[i] > 0) b = b | m_mask[i];
        return b;
    endfunction

    function automatic logic m_req(int i);
        return !rst && (m_rem[i] == 0) && in_valid[i] && (dst_b[i] != 4'h0)
               && ((dst_b[i] & m_busy()) == 4'h0);
    endfunction

    function automatic logic m_pop(int i);
        return !rst && (m_rem[i] > 0) && ((out_ready & m_mask[i]) == m_mask[i]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_rem[i] = 0; m_mask[i] = '0; m_stall[i] = 0;
        end
        m_elen = 1'b0; m_egrant = 1'b0; m_estall = 1'b0;
    endtask

    task automatic check_outputs();
        logic [3:0] busy, req_e, pop_e;
        logic [7:0] sel_e;
        logic [15:0] adst_e;
        busy = m_busy(); req_e = '0; pop_e = '0; sel_e = '0; adst_e = '0;
        for (int i = 0; i < 4; i++) begin
            req_e[i] = m_req(i);
            pop_e[i] = m_pop(i);
            if (req_e[i]) adst_e[4*i +: 4] = dst_b[i];
            for (int o = 0; o < 4; o++)
                if (m_rem[i] > 0 && m_mask[i][o]) sel_e[2*o +: 2] = 2'(i);
        end
        chk("in_pop",    32'(in_pop),    32'(pop_e));
        chk("arb_req",   32'(arb_req),   32'(req_e));
        chk("arb_dst",   32'({arb_dst3, arb_dst2, arb_dst1, arb_dst0}), 32'(adst_e));
        chk("out_valid", 32'(out_valid), 32'(busy));
        chk("out_busy",  32'(out_busy),  32'(busy));
        chk("out_sel",   32'({out_sel3, out_sel2, out_sel1, out_sel0}), 32'(sel_e));
        chk("err_flags", 32'({err_len, err_grant, err_stall}),
            32'({m_elen, m_egrant, m_estall}));
    endtask

    task automatic model_step();
        logic [3:0] req_v, pop_v, claimed;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            req_v[i] = m_req(i);
            pop_v[i] = m_pop(i);
        end
        for (int i = 0; i < 4; i++) begin
            if (m_rem[i] > 0 && m_stall[i] == SMAX) m_estall = 1'b1;
            if (pop_v[i]) begin
                m_rem[i]--;
                m_stall[i] = 0;
            end else if (m_rem[i] > 0 && m_stall[i] < SMAX) begin
                m_stall[i]++;
            end
        end
        claimed = '0;
        for (int i = 0; i < 4; i++) begin
            if (arb_grant[i]) begin
                if (!req_v[i] || ((dst_b[i] & claimed) != 4'h0)) begin
                    m_egrant = 1'b1;
                end else begin
                    m_rem[i]   = (len_b[i] == 6'd0) ? 1 : int'(len_b[i]);
                    if (len_b[i] == 6'd0) m_elen = 1'b1;
                    m_mask[i]  = dst_b[i];
                    m_stall[i] = 0;
                    claimed    = claimed | dst_b[i];
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        for (int i = 0; i < 4; i++) pop_cnt[i] += int'(in_pop[i]);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = '0; arb_grant = '0; out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            dst_b[i] = '0; len_b[i] = '0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic clr_pops();
        for (int i = 0; i < 4; i++) pop_cnt[i] = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_reset();
        clr_pops();
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_busy", 32'(out_busy), 32'h0);
        chk("rst_errs", 32'({err_len, err_grant, err_stall}), 32'h0);

        // unicast, three flits
        in_valid = 4'b0001; dst_b[0] = 4'b0001; len_b[0] = 6'd3; arb_grant = 4'b0001;
        #1;
        chk("uni_req", 32'(arb_req), 32'h1);
        tick();
        in_valid = '0; arb_grant = '0; clr_pops();
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk("uni_valid", 32'(out_valid[0]), 32'h1);
            tick();
        end
        chk("uni_pops", 32'(pop_cnt[0]), 32'd3);
        chk("uni_release", 32'(out_busy[0]), 32'h0);

        // multicast with backpressure
        do_reset();
        in_valid = 4'b0100; dst_b[2] = 4'b0110; len_b[2] = 6'd2; arb_grant = 4'b0100;
        tick();
        in_valid = '0; arb_grant = '0; out_ready = 4'b0100; clr_pops();
        chk("mc_sel", 32'({out_sel2, out_sel1}), 32'({2'd2, 2'd2}));
        tick(); tick();
        chk("mc_stall_pops", 32'(pop_cnt[2]), 32'd0);
        out_ready = 4'b0110;
        tick(); tick();
        chk("mc_pops", 32'(pop_cnt[2]), 32'd2);
        chk("mc_release", 32'(out_busy), 32'h0);

        // contention for output 3
        do_reset();
        in_valid = 4'b1010; dst_b[1] = 4'b1000; len_b[1] = 6'd3;
        dst_b[3] = 4'b1000; len_b[3] = 6'd1; arb_grant = 4'b0010;
        tick();
        in_valid = 4'b1000; arb_grant = '0;
        for (int k = 1; k <= 3; k++) begin
            chk("cont_blocked", 32'(arb_req[3]), 32'h0);
            tick();
        end
        chk("cont_free", 32'(arb_req[3]), 32'h1);
        arb_grant = 4'b1000;
        tick();
        in_valid = '0; arb_grant = '0;
        chk("cont_sel3", 32'(out_sel3), 32'd3);
        tick(); tick();

        // zero length and stray grant
        do_reset();
        in_valid = 4'b0001; dst_b[0] = 4'b0001; len_b[0] = 6'd0; arb_grant = 4'b0001;
        tick();
        in_valid = '0; arb_grant = '0; clr_pops();
        tick();
        chk("len0_pops", 32'(pop_cnt[0]), 32'd1);
        chk("len0_err", 32'(err_len), 32'h1);
        chk("len0_release", 32'(out_busy), 32'h0);
        chk("len0_no_grant_err", 32'(err_grant), 32'h0);
        arb_grant = 4'b0100;
        tick();
        arb_grant = '0;
        chk("stray_err", 32'(err_grant), 32'h1);
        chk("stray_busy", 32'(out_busy), 32'h0);

        // two grants on one output: lower port wins
        do_reset();
        in_valid = 4'b0011; dst_b[0] = 4'b0011; len_b[0] = 6'd1;
        dst_b[1] = 4'b0010; len_b[1] = 6'd1; arb_grant = 4'b0011;
        tick();
        in_valid = '0; arb_grant = '0;
        chk("conf_busy", 32'(out_busy), 32'h3);
        chk("conf_sel1", 32'(out_sel1), 32'd0);
        chk("conf_err", 32'(err_grant), 32'h1);
        tick(); tick();

        // 254 stalled cycles: just below the limit
        do_reset();
        in_valid = 4'b0001; dst_b[0] = 4'b0001; len_b[0] = 6'd2; arb_grant = 4'b0001;
        out_ready = '0;
        tick();
        in_valid = '0; arb_grant = '0;
        repeat (254) tick();
        out_ready = 4'hF;
        tick(); tick();
        chk("stall254_err", 32'(err_stall), 32'h0);
        chk("stall254_done", 32'(out_busy), 32'h0);

        // 255 stalled cycles: limit reached, transfer still completes
        do_reset();
        in_valid = 4'b0001; dst_b[0] = 4'b0001; len_b[0] = 6'd2; arb_grant = 4'b0001;
        out_ready = '0;
        tick();
        in_valid = '0; arb_grant = '0; clr_pops();
        repeat (255) tick();
        out_ready = 4'hF;
        tick(); tick(); tick();
        chk("stall255_err", 32'(err_stall), 32'h1);
        chk("stall255_pops", 32'(pop_cnt[0]), 32'd2);
        chk("stall255_done", 32'(out_busy), 32'h0);

        // reset in the middle of a packet
        do_reset();
        in_valid = 4'b0001; dst_b[0] = 4'b0001; len_b[0] = 6'd5; arb_grant = 4'b0001;
        tick();
        in_valid = '0; arb_grant = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_outs", 32'({in_pop, out_valid, out_busy, arb_req}), 32'h0);
        chk("mid_rst_sel", 32'({out_sel3, out_sel2, out_sel1, out_sel0}), 32'h0);
        in_valid = 4'b0001; dst_b[0] = 4'b0001; len_b[0] = 6'd1;
        #1;
        chk("mid_rst_req", 32'(arb_req), 32'h1);
        arb_grant = 4'b0001;
        tick();
        in_valid = '0; arb_grant = '0;
        tick();

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] req_v;
            rst = ($urandom_range(0, 199) == 0);
            in_valid = 4'($urandom());
            for (int i = 0; i < 4; i++) begin
                dst_b[i] = 4'($urandom_range(0, 15));
                len_b[i] = 6'($urandom_range(0, 4));
                out_ready[i] = ($urandom_range(0, 9) < 8);
            end
            for (int i = 0; i < 4; i++) req_v[i] = m_req(i);
            arb_grant = req_v & 4'($urandom());
            if ($urandom_range(0, 39) == 0) arb_grant = arb_grant ^ 4'($urandom());
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
